// File: rtl/controlador_sequenciador.sv
`default_nettype none
// ============================================================================
// Module   : controlador_sequenciador
// Brief    : SAP-1 controller-sequencer; six-state one-hot ring counter plus
//            opcode decode producing the 12-bit control word and halt flag.
// Revision : 1.0
// ============================================================================
module controlador_sequenciador #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt,
    output logic [5:0] t_estado
);

    // One-hot encoding: bits [5:0] double as the visible ring state.
    typedef enum logic [6:0] {
        S_T1   = 7'b0000001,
        S_T2   = 7'b0000010,
        S_T3   = 7'b0000100,
        S_T4   = 7'b0001000,
        S_T5   = 7'b0010000,
        S_T6   = 7'b0100000,
        S_HALT = 7'b1000000
    } state_t;

    state_t state_q;
    state_t state_d;

    logic w_op_mem;

    assign w_op_mem = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);

    always_comb begin
        state_d = S_T1;
        case (state_q)
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = (opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_T1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_T1;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_T1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        cp = 1'b0;
        ep = 1'b0;
        lm = 1'b0;
        ce = 1'b0;
        li = 1'b0;
        ei = 1'b0;
        la = 1'b0;
        ea = 1'b0;
        su = 1'b0;
        eu = 1'b0;
        lb = 1'b0;
        lo = 1'b0;
        case (state_q)
            S_T1: begin
                ep = 1'b1;
                lm = 1'b1;
            end
            S_T2: begin
                cp = 1'b1;
            end
            S_T3: begin
                ce = 1'b1;
                li = 1'b1;
            end
            S_T4: begin
                if (w_op_mem) begin
                    ei = 1'b1;
                    lm = 1'b1;
                end else if (opcode == OP_OUT) begin
                    ea = 1'b1;
                    lo = 1'b1;
                end
            end
            S_T5: begin
                if (opcode == OP_LDA) begin
                    ce = 1'b1;
                    la = 1'b1;
                end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    ce = 1'b1;
                    lb = 1'b1;
                end
            end
            S_T6: begin
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    eu = 1'b1;
                    la = 1'b1;
                    su = (opcode == OP_SUB);
                end
            end
            default: begin
            end
        endcase
    end

    assign hlt      = state_q[6];
    assign t_estado = state_q[5:0];

endmodule
`default_nettype wire

// File: doc/controlador_sequenciador.md
# controlador_sequenciador

SAP-1 controller-sequencer: a six-state ring counter plus opcode decoder that issues the 12-bit control word steering every bus participant. This includes the `sub`/`eu` pair consumed by the adder/subtractor and the load strobes that read its result back off the W bus. It sits between the instruction register (opcode source) and all datapath blocks, and it is the only initiator of bus transfers in the machine.

## Interface

Parameters:
- `OP_LDA`, 4'b0000, load accumulator from memory
- `OP_ADD`, 4'b0001, A <= A + mem
- `OP_SUB`, 4'b0010, A <= A - mem
- `OP_OUT`, 4'b1110, output register <= A
- `OP_HLT`, 4'b1111, stop sequencing

Ports:
- `clk` in 1: single system clock; all state changes on the rising edge.
- `clr_n` in 1: asynchronous, active-low reset.
- `opcode` in 4: upper nibble of the instruction register.
- `cp` out 1: program counter increment.
- `ep` out 1: program counter drives bus.
- `lm` out 1: MAR load.
- `ce` out 1: RAM drives bus.
- `li` out 1: IR load.
- `ei` out 1: IR address nibble drives bus.
- `la` out 1: accumulator load.
- `ea` out 1: accumulator drives bus.
- `su` out 1: subtract select (to `sub`).
- `eu` out 1: adder/subtractor drives bus.
- `lb` out 1: B register load.
- `lo` out 1: output register load.
- `hlt` out 1: halted flag.
- `t_estado` out 6: one-hot ring state T1..T6 (bit 0 = T1); all zeros when halted.

All outputs are active-high. Downstream inversion, if any, is the consumer's job.

## Operation

- Ring counter states: T1→T2→T3→T4→T5→T6→T1, one state per clock. There is one extra state, HALT.
- Control word per state (signals not listed are 0):
  - T1: `ep`, `lm`
  - T2: `cp`
  - T3: `ce`, `li`
  - T4: LDA/ADD/SUB: `ei`, `lm`; OUT: `ea`, `lo`; HLT or undefined: none
  - T5: LDA: `ce`, `la`; ADD/SUB: `ce`, `lb`; others: none
  - T6: ADD: `eu`, `la`; SUB: `su`, `eu`, `la`; others: none
- Outputs are a combinational decode of the registered state and `opcode`. They are glitch-free with respect to state because state is one-hot.
- `opcode` is not latched. The IR must hold it stable from the end of T3 through T6, and its value is ignored in T1–T3.
- Undefined opcodes execute as a 6-state NOP with no bus drivers enabled in T4–T6.
- HLT: at the rising edge ending T4 with `opcode == OP_HLT`, the block enters HALT.
  - In HALT: `hlt` = 1, `t_estado` = 0, and all control outputs are 0.
  - HALT persists regardless of `opcode` and is left only via `clr_n`.
- Bus exclusivity invariant: at most one of {`ep`, `ce`, `ei`, `ea`, `eu`} is 1 in any state.
- `su` is 1 only when `eu` is 1.

## Timing

- Reset (`clr_n` = 0, asynchronous):
  - State forces to T1 immediately: `t_estado` = 6'b000001, `ep` = `lm` = 1, all other controls 0, `hlt` = 0.
  - The state holds while `clr_n` is low.
  - The first advance is the first rising edge after `clr_n` deasserts.
- Reset mid-instruction, including inside HALT: the block aborts immediately to T1 with no further strobes.
- Instruction latency: exactly 6 clocks per instruction. The next fetch T1 follows T6 with no idle cycle.
- HLT latency: T1–T4 run (4 clocks), then HALT begins on the next edge.
- Bus transfers: the driver enable and the load strobe are asserted in the same state. The load takes effect at the rising edge that ends that state.
- `clr_n` asserted in the same cycle as a clock edge: reset wins.

## Test plan

- Reset: hold `clr_n` = 0 across 3 edges → `t_estado` = 000001, `ep` = `lm` = 1, `hlt` = 0. Release → `t_estado` sequence 000010, 000100, 001000, 010000, 100000, 000001 on successive edges.
- LDA (`opcode` = 0000 from T4): T4 shows `ei`, `lm`; T5 shows `ce`, `la`; T6 is all zero; no `eu` at any point.
- SUB (`opcode` = 0010): T5 shows `ce`, `lb`; T6 shows `su` = `eu` = `la` = 1. ADD (0001) gives the same T6 with `su` = 0. Check the bus-exclusivity invariant every cycle.
- OUT then HLT: OUT T4 shows `ea`, `lo`. In the following instruction with `opcode` = 1111, after the T4 edge: `hlt` = 1, outputs all 0, `t_estado` = 0. Hold 20 clocks with `opcode` toggling → unchanged.
- Reset mid-operation: assert `clr_n` low asynchronously during T5 of an ADD, then in HALT → immediate `t_estado` = 000001 with `ep`, `lm` only. Normal fetch resumes after release.
- Undefined opcode 0111: T4–T6 have all controls 0, and the instruction still takes exactly 6 clocks before the next T1.
